// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_pkg
//  Description : Shared constants and elaboration-time helpers for the
//                SECDED encoder (and the matching decoder). Maps payload bit
//                indices to Hamming positions and builds parity masks.
//  Revision    : 1.0  initial release
// ============================================================================
package ecc_pkg;

    // Widest payload any SECDED block in this family supports
    localparam int ECC_MAX_DATA_W = 64;

    // Check-bit count: smallest r with 2^r >= data_w + r + 1, plus one
    // overall-parity bit. Yields 5/6/7/8 for 8/16/32/64-bit payloads.
    function automatic int chk_w(input int data_w);
        int r;
        r = 0;
        for (int k = 8; k >= 1; k--) begin
            if ((1 << k) >= (data_w + k + 1)) begin
                r = k;
            end
        end
        return r + 1;
    endfunction

    // Hamming position (1-based) of payload bit idx. Positions that are
    // powers of two belong to check bits, so step over each one that lies
    // at or below the running position.
    function automatic int ecc_pos(input int idx);
        int n;
        n = idx + 1;
        for (int k = 0; k < 8; k++) begin
            if ((1 << k) <= n) begin
                n = n + 1;
            end
        end
        return n;
    endfunction

    // Bit i of the result is set when payload bit i contributes to
    // Hamming check bit k (its position has bit k set).
    function automatic logic [ECC_MAX_DATA_W-1:0] ecc_mask(input int k);
        logic [ECC_MAX_DATA_W-1:0] m;
        int                        p;
        m = '0;
        for (int i = 0; i < ECC_MAX_DATA_W; i++) begin
            p    = ecc_pos(i);
            m[i] = (((p >> k) & 1) != 0);
        end
        return m;
    endfunction

endpackage : ecc_pkg
`default_nettype wire

// File: rtl/ecc_secded_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_secded_encoder_if
//  Description : Valid/ready word stream into the SECDED encoder and
//                codeword stream out of it, plus the output word counter.
//                master = traffic source/sink side, slave = encoder side.
//  Revision    : 1.0  initial release
// ============================================================================
interface ecc_secded_encoder_if #(
    parameter int DATA_W = 32,
    parameter int CHK_W  = ecc_pkg::chk_w(DATA_W),
    parameter int CW_W   = DATA_W + CHK_W
);

    // Input word channel
    logic              i_enable_ecc;
    logic              i_wvalid;
    logic              o_wready;
    logic [DATA_W-1:0] i_wdata;
    logic [CW_W-1:0]   i_inj_mask;

    // Output codeword channel
    logic              o_wvalid;
    logic              i_rready;
    logic [CW_W-1:0]   o_wdata;
    logic              o_ecc_en;
    logic [15:0]       o_word_cnt;

    modport master (
        output i_enable_ecc,
        output i_wvalid,
        input  o_wready,
        output i_wdata,
        output i_inj_mask,
        input  o_wvalid,
        output i_rready,
        input  o_wdata,
        input  o_ecc_en,
        input  o_word_cnt
    );

    modport slave (
        input  i_enable_ecc,
        input  i_wvalid,
        output o_wready,
        input  i_wdata,
        input  i_inj_mask,
        output o_wvalid,
        input  i_rready,
        output o_wdata,
        output o_ecc_en,
        output o_word_cnt
    );

endinterface : ecc_secded_encoder_if
`default_nettype wire

// File: rtl/ecc_secded_calc.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_secded_calc
//  Description : Purely combinational SECDED check-bit generator. The low
//                CHK_W-1 bits are Hamming parities over the payload, the top
//                bit is overall parity of payload plus Hamming bits. Shared
//                with the decoder so both sides use identical parity trees.
//  Revision    : 1.0  initial release
// ============================================================================
module ecc_secded_calc
    import ecc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W  = chk_w(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [CHK_W-1:0]  o_check
);

    logic [CHK_W-2:0] w_hamming;

    // One XOR tree per Hamming check bit; the membership mask is fixed at
    // elaboration so each tree only sees the payload bits it covers.
    for (genvar k = 0; k < CHK_W - 1; k++) begin : g_chk
        localparam logic [ECC_MAX_DATA_W-1:0] c_mask = ecc_mask(k);
        assign w_hamming[k] = ^(i_data & c_mask[DATA_W-1:0]);
    end

    // Overall parity closes the code to distance 4 (double-error detect)
    assign o_check = {^{i_data, w_hamming}, w_hamming};

endmodule : ecc_secded_calc
`default_nettype wire

// File: rtl/ecc_secded_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_secded_encoder
//  Description : Two-stage valid/ready SECDED encoder. S1 captures the
//                payload, mode flag and injection mask; the check bits are
//                computed from S1 and the finished (optionally corrupted)
//                codeword is registered into S2, which drives the output.
//                Full throughput of one word per cycle; only o_wready
//                depends combinationally on i_rready.
//  Revision    : 1.0  initial release
// ============================================================================
module ecc_secded_encoder
    import ecc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W  = chk_w(DATA_W),
    parameter int CW_W   = DATA_W + CHK_W
) (
    input  logic                 i_aclk,
    input  logic                 i_areset,
    ecc_secded_encoder_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // S1: captured input word
    logic              s1_v_q,    s1_v_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [CW_W-1:0]   s1_mask_q, s1_mask_d;
    logic              s1_ecc_q,  s1_ecc_d;

    // S2: finished codeword presented downstream
    logic              s2_v_q,    s2_v_d;
    logic [CW_W-1:0]   s2_cw_q,   s2_cw_d;
    logic              s2_ecc_q,  s2_ecc_d;

    // Output handshake counter
    logic [15:0]       word_cnt_q, word_cnt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_s2_free;   // S2 empty or emptying this cycle
    logic              w_s1_adv;    // S1 moves into S2 this cycle
    logic              w_wready;
    logic              w_in_hs;
    logic              w_out_hs;
    logic [CHK_W-1:0]  w_check;
    logic [CW_W-1:0]   w_cw;

    // Check bits for the word currently held in S1
    ecc_secded_calc #(
        .DATA_W (DATA_W),
        .CHK_W  (CHK_W)
    ) u_calc (
        .i_data  (s1_data_q),
        .o_check (w_check)
    );

    // Handshake qualification; S1 frees up whenever it can advance, which
    // is what lets a full pipeline shift in and out in the same cycle.
    always_comb begin
        w_s2_free = !s2_v_q || bus.i_rready;
        w_s1_adv  = s1_v_q && w_s2_free;
        w_wready  = !s1_v_q || w_s2_free;
        w_in_hs   = bus.i_wvalid && w_wready;
        w_out_hs  = s2_v_q && bus.i_rready;
    end

    // Codeword assembly: bypass zeroes the check field, then the injection
    // mask is applied in both modes.
    always_comb begin
        w_cw = {w_check & {CHK_W{s1_ecc_q}}, s1_data_q} ^ s1_mask_q;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // S1 loads on accept and drains when it advances into S2
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        s1_mask_d = s1_mask_q;
        s1_ecc_d  = s1_ecc_q;
        if (w_s1_adv) begin
            s1_v_d = 1'b0;
        end
        if (w_in_hs) begin
            s1_v_d    = 1'b1;
            s1_data_d = bus.i_wdata;
            s1_mask_d = bus.i_inj_mask;
            s1_ecc_d  = bus.i_enable_ecc;
        end
    end

    // S2 only changes when refilled from S1 or drained downstream, so the
    // presented codeword is frozen during a stall.
    always_comb begin
        s2_v_d   = s2_v_q;
        s2_cw_d  = s2_cw_q;
        s2_ecc_d = s2_ecc_q;
        if (w_s1_adv) begin
            s2_v_d   = 1'b1;
            s2_cw_d  = w_cw;
            s2_ecc_d = s1_ecc_q;
        end else if (w_out_hs) begin
            s2_v_d   = 1'b0;
        end
    end

    // Free-running 16-bit count of delivered codewords, natural wrap
    always_comb begin
        word_cnt_d = word_cnt_q + {15'd0, w_out_hs};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // All pipeline state; reset drops in-flight words and the count
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            s1_v_q     <= 1'b0;
            s1_data_q  <= '0;
            s1_mask_q  <= '0;
            s1_ecc_q   <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_cw_q    <= '0;
            s2_ecc_q   <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_data_q  <= s1_data_d;
            s1_mask_q  <= s1_mask_d;
            s1_ecc_q   <= s1_ecc_d;
            s2_v_q     <= s2_v_d;
            s2_cw_q    <= s2_cw_d;
            s2_ecc_q   <= s2_ecc_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_wready   = w_wready;
    assign bus.o_wvalid   = s2_v_q;
    assign bus.o_wdata    = s2_cw_q;
    assign bus.o_ecc_en   = s2_ecc_q;
    assign bus.o_word_cnt = word_cnt_q;

endmodule : ecc_secded_encoder
`default_nettype wire

// File: tb/tb_ecc_secded_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ecc_secded_encoder
//  Description : Directed self-checking bench for the 32-bit SECDED encoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ecc_secded_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ecc_secded_encoder_if #(.DATA_W(32)) bus ();

    ecc_secded_encoder #(.DATA_W(32)) dut (
        .i_aclk   (clk),
        .i_areset (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called right after a negedge: offer one word, confirm 2-cycle latency
    // and the delivered codeword. Returns at a negedge with the word on the
    // output and i_rready high.
    task automatic send_check(input string tag, input logic ecc, input logic [31:0] d,
                              input logic [38:0] m, input logic [38:0] exp_cw,
                              input logic exp_en);
        bus.i_enable_ecc = ecc;
        bus.i_wdata      = d;
        bus.i_inj_mask   = m;
        bus.i_wvalid     = 1'b1;
        bus.i_rready     = 1'b1;
        #1;
        check({tag, "_wready"}, bus.o_wready, 1'b1);
        @(negedge clk);
        bus.i_wvalid = 1'b0;
        check({tag, "_lat1"}, bus.o_wvalid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, bus.o_wvalid, 1'b1);
        check({tag, "_data"}, bus.o_wdata, exp_cw);
        check({tag, "_ecc_en"}, bus.o_ecc_en, exp_en);
    endtask

    logic [31:0] sd [10];
    logic [6:0]  sc [10];
    logic [38:0] q [$];
    logic [38:0] e;
    logic [38:0] prev_cw;
    logic        prev_stall;
    int          idx;
    int          got;

    initial begin
        // Hand-computed codeword table
        sd[0] = 32'h0000_0001; sc[0] = 7'h43;
        sd[1] = 32'h0000_0002; sc[1] = 7'h45;
        sd[2] = 32'h0000_0000; sc[2] = 7'h00;
        sd[3] = 32'h0000_0003; sc[3] = 7'h06;
        sd[4] = 32'h0000_0004; sc[4] = 7'h46;
        sd[5] = 32'h8000_0000; sc[5] = 7'h26;
        sd[6] = 32'h0000_0001; sc[6] = 7'h43;
        sd[7] = 32'h0000_0002; sc[7] = 7'h45;
        sd[8] = 32'h0000_0000; sc[8] = 7'h00;
        sd[9] = 32'h0000_0003; sc[9] = 7'h06;

        bus.i_enable_ecc = 1'b0;
        bus.i_wvalid     = 1'b0;
        bus.i_wdata      = '0;
        bus.i_inj_mask   = '0;
        bus.i_rready     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wvalid", bus.o_wvalid, 1'b0);
        check("rst_wdata", bus.o_wdata, 39'h0);
        check("rst_ecc_en", bus.o_ecc_en, 1'b0);
        check("rst_cnt", bus.o_word_cnt, 16'h0);
        check("rst_wready", bus.o_wready, 1'b1);

        // First word in the first cycle after reset release
        rst = 1'b0;
        send_check("w1", 1'b1, 32'h0000_0001, 39'h0, {7'h43, 32'h0000_0001}, 1'b1);
        send_check("w2", 1'b1, 32'h0000_0002, 39'h0, {7'h45, 32'h0000_0002}, 1'b1);
        send_check("w0", 1'b1, 32'h0000_0000, 39'h0, {7'h00, 32'h0000_0000}, 1'b1);
        send_check("w3", 1'b1, 32'h0000_0003, 39'h0, {7'h06, 32'h0000_0003}, 1'b1);
        send_check("w4", 1'b1, 32'h0000_0004, 39'h0, {7'h46, 32'h0000_0004}, 1'b1);
        send_check("wmsb", 1'b1, 32'h8000_0000, 39'h0, {7'h26, 32'h8000_0000}, 1'b1);
        send_check("byp", 1'b0, 32'hDEAD_BEEF, 39'h1, {7'h00, 32'hDEAD_BEEE}, 1'b0);
        send_check("inj_chk", 1'b1, 32'h0000_0001, 39'h1 << 32, {7'h42, 32'h0000_0001}, 1'b1);
        send_check("byp_inj", 1'b0, 32'h1234_5678, 39'h1 << 38, {7'h40, 32'h1234_5678}, 1'b0);
        @(negedge clk);
        check("cnt_after_singles", bus.o_word_cnt, 16'd9);

        // Mode change with a word already in flight
        bus.i_enable_ecc = 1'b1; bus.i_wdata = 32'h1; bus.i_inj_mask = '0;
        bus.i_wvalid = 1'b1; bus.i_rready = 1'b1;
        @(negedge clk);
        bus.i_enable_ecc = 1'b0;
        @(negedge clk);
        bus.i_wvalid = 1'b0;
        check("mode_a_data", bus.o_wdata, {7'h43, 32'h1});
        check("mode_a_en", bus.o_ecc_en, 1'b1);
        @(negedge clk);
        check("mode_b_data", bus.o_wdata, {7'h00, 32'h1});
        check("mode_b_en", bus.o_ecc_en, 1'b0);

        // Back-to-back stream with a stall window
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idx = 0; got = 0; prev_stall = 1'b0; prev_cw = '0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            @(negedge clk);
            if (prev_stall) check("stall_hold", bus.o_wdata, prev_cw);
            bus.i_rready = !(cyc >= 3 && cyc <= 6);
            bus.i_wvalid = (idx < 10);
            if (idx < 10) begin
                bus.i_enable_ecc = 1'b1;
                bus.i_wdata      = sd[idx];
                bus.i_inj_mask   = 39'(idx);
            end
            #1;
            if (bus.i_wvalid && bus.o_wready) begin
                q.push_back({sc[idx], sd[idx]} ^ 39'(idx));
                idx++;
            end
            if (bus.o_wvalid && bus.i_rready) begin
                if (q.size() != 0) e = q.pop_front();
                else e = 'x;
                check("stream_word", bus.o_wdata, e);
                got++;
            end
            prev_stall = bus.o_wvalid && !bus.i_rready;
            prev_cw    = bus.o_wdata;
        end
        bus.i_wvalid = 1'b0;
        check("stream_delivered", got, 10);
        @(negedge clk);
        check("stream_cnt", bus.o_word_cnt, 16'd10);
        check("stream_drained", bus.o_wvalid, 1'b0);

        // Reset with two words in flight
        bus.i_enable_ecc = 1'b1; bus.i_inj_mask = '0; bus.i_rready = 1'b1;
        bus.i_wdata = 32'h0000_0003; bus.i_wvalid = 1'b1;
        @(negedge clk);
        bus.i_wdata = 32'h0000_0004;
        @(negedge clk);
        bus.i_wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_wvalid", bus.o_wvalid, 1'b0);
        check("midrst_cnt", bus.o_word_cnt, 16'd0);
        check("midrst_wready", bus.o_wready, 1'b1);
        rst = 1'b0;
        send_check("post_rst", 1'b1, 32'h0000_0002, 39'h0, {7'h45, 32'h0000_0002}, 1'b1);
        @(negedge clk);
        check("post_rst_cnt", bus.o_word_cnt, 16'd1);
        check("post_rst_empty", bus.o_wvalid, 1'b0);

        // Counter wrap
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_enable_ecc = 1'b0; bus.i_wdata = '0; bus.i_inj_mask = '0;
        bus.i_wvalid = 1'b1; bus.i_rready = 1'b1;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (bus.o_word_cnt == 16'hFFFF) break;
        end
        check("wrap_preload", bus.o_word_cnt, 16'hFFFF);
        check("wrap_valid", bus.o_wvalid, 1'b1);
        @(negedge clk);
        check("wrap_zero", bus.o_word_cnt, 16'h0000);
        bus.i_wvalid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ecc_secded_encoder
`default_nettype wire

// File: doc/ecc_secded_encoder.md
ECC_SECDED_ENCODER -- requirements
Module: ecc_secded_encoder

Interface
REQ-001 Parameter DATA_W, default 32, payload width; legal values 8, 16, 32, 64.
REQ-002 Parameter CHK_W, default ecc_pkg::chk_w(DATA_W), check width; the value is derived and never overridden (5/6/7/8 for DATA_W 8/16/32/64).
REQ-003 Parameter CW_W, default DATA_W+CHK_W, codeword width.
REQ-004 Clock and reset: one clock, i_aclk; reset i_areset is synchronous and active-high.
REQ-005 i_aclk  input  1  clock; all state is updated on its rising edge.
REQ-006 i_areset  input  1  synchronous, active-high reset.
REQ-007 i_enable_ecc  input  1  1 = encode, 0 = bypass (check bits forced to 0); sampled per word at accept.
REQ-008 i_wvalid  input  1  input word valid.
REQ-009 o_wready  output  1  block can accept the input word.
REQ-010 i_wdata  input  DATA_W  payload.
REQ-011 i_inj_mask  input  CW_W  error-injection mask for HARQ test; sampled at accept.
REQ-012 o_wvalid  output  1  codeword valid.
REQ-013 i_rready  input  1  downstream accepts the codeword.
REQ-014 o_wdata  output  CW_W  codeword {check[CHK_W-1:0], data[DATA_W-1:0]}.
REQ-015 o_ecc_en  output  1  i_enable_ecc value travelling with the word.
REQ-016 o_word_cnt  output  16  count of output handshakes; wraps 0xFFFF->0.

Function
REQ-017 An input handshake occurs when i_wvalid && o_wready; an output handshake occurs when o_wvalid && i_rready.
REQ-018 Two-stage pipeline, S1 (capture) and S2 (output register); latency is 2 cycles from input handshake to o_wvalid with i_rready held high.
REQ-019 o_wready = !s1_v || !s2_v || i_rready; this combinational path is the only one from i_rready.
REQ-020 Sustained throughput is 1 word/cycle when i_rready is held high.
REQ-021 S1 advances to S2 when S2 is empty or emptying; S2 holds when o_wvalid && !i_rready.
REQ-022 o_wdata and o_ecc_en remain stable while o_wvalid is high and i_rready is low.
REQ-023 Hamming positions: bit positions 1.., powers of two reserved; data bit i maps in ascending order to the i-th non-power-of-two position (3, 5, 6, 7, 9, ...).
REQ-024 check[k] for k<CHK_W-1 = XOR of data bits whose position has bit k set.
REQ-025 check[CHK_W-1] = XOR of all data bits and check[CHK_W-2:0] (overall parity, SECDED).
REQ-026 Check bits are computed combinationally from S1 and registered into S2.
REQ-027 With the word's ecc flag = 0, check = 0 and the data passes unchanged.
REQ-028 o_wdata = encoded codeword XOR the word's inj_mask; injection also applies in bypass mode.
REQ-029 o_word_cnt increments by 1 on each output handshake and wraps 0xFFFF->0.
REQ-030 A change of i_enable_ecc affects only words accepted afterwards; words in flight keep their sampled mode.
REQ-031 Simultaneous input and output handshakes with S1 and S2 full shift the pipeline without loss or duplication.

Reset
REQ-032 While i_areset is high: s1_v = s2_v = 0, o_wvalid = 0, o_wdata = 0, o_ecc_en = 0, o_word_cnt = 0, o_wready = 1.
REQ-033 Reset asserted mid-operation discards in-flight words; no output handshake is counted in the reset cycle.
REQ-034 The first input handshake is possible in the first cycle after i_areset deasserts.

Structure
REQ-035 Package ecc_pkg holds the function chk_w(), the function ecc_pos(i) (data index to Hamming position), and constant ECC_MAX_DATA_W = 64.
REQ-036 Sub-module ecc_secded_calc (combinational, parameter DATA_W) computes check[]; the parity logic is reused by the future decoder.

Verification
REQ-037 DATA_W=32, ecc=1, data 0x00000001, mask 0 -> o_wdata = {7'h43, 32'h00000001} 2 cycles after accept.
REQ-038 DATA_W=32, ecc=1, data 0x00000002 -> check 7'h45; data 0x00000000 -> check 7'h00.
REQ-039 ecc=0, data 0xDEADBEEF, mask bit 0 set -> o_wdata = {7'h00, 32'hDEADBEEE}, o_ecc_en = 0.
REQ-040 10 back-to-back words with i_rready low in cycles 3-6 -> all 10 delivered in order, no drop or duplicate, o_wdata stable while stalled, o_word_cnt = 10.
REQ-041 i_areset pulsed with 2 words in flight -> o_wvalid = 0 and o_word_cnt = 0 the next cycle; a new word is delivered 2 cycles after its accept.
REQ-042 Preload o_word_cnt to 0xFFFF via 65535 handshakes, then one more handshake -> o_word_cnt = 0x0000.
